// File: rtl/bitrev_frame_sched.sv
// Frame scheduler around the ping-pong bit-reverse core: admission, point-size latching,
// bank occupancy and SOP/EOP tagging. Optional counters under BITREV_SCHED_STATS_EN.
module bitrev_frame_sched #(
    parameter int DWIDTH    = 32,
    parameter int PWIDTH    = 11,
    parameter int MIN_POINT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PWIDTH-1:0] cfg_point,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] c_data,
    output logic              c_valid,
    output logic [PWIDTH-1:0] c_point,
    input  logic [DWIDTH-1:0] c_o_data,
    input  logic              c_o_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    output logic              m_sop,
    output logic              m_eop,
    output logic              err_point,
    output logic              busy
`ifdef BITREV_SCHED_STATS_EN
    ,
    output logic [15:0]       o_frames_in,
    output logic [15:0]       o_frames_out,
    output logic [15:0]       o_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PWIDTH-1:0] MAX_POINT = PWIDTH'(1024);
    localparam logic [PWIDTH-1:0] P_ZERO    = {PWIDTH{1'b0}};

    function automatic logic point_legal(input logic [PWIDTH-1:0] p);
        point_legal = (p != P_ZERO) && ((p & (p - PWIDTH'(1))) == P_ZERO) &&
                      (p >= PWIDTH'(MIN_POINT)) && (p <= MAX_POINT);
    endfunction

    state_t            state_r, state_s;
    logic [PWIDTH-1:0] wcnt_r, rcnt_r, last_s;
    logic [1:0]        pending_r, pending_s;
    logic              legal_s, load_point_s, err_s;
    logic              wr_done_s, rd_live_s, rd_eop_s;

    assign legal_s   = point_legal(cfg_point);
    assign last_s    = c_point - PWIDTH'(1);
    assign wr_done_s = s_valid & s_ready & (wcnt_r == last_s);
    // Core output is only meaningful while a frame is actually pending in a bank.
    assign rd_live_s = c_o_valid & (pending_r != 2'd0);
    assign rd_eop_s  = rd_live_s & (rcnt_r == last_s);

    // Bank occupancy: simultaneous fill-complete and drain-complete cancel out.
    always_comb begin
        pending_s = pending_r;
        case ({wr_done_s, rd_eop_s})
            2'b10:   pending_s = pending_r + 2'd1;
            2'b01:   pending_s = pending_r - 2'd1;
            default: pending_s = pending_r;
        endcase
    end

    // Next-state and point/err decisions.
    always_comb begin
        state_s      = state_r;
        load_point_s = 1'b0;
        err_s        = err_point;
        case (state_r)
            ST_IDLE: begin
                if (!legal_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                    // A size change must wait until every in-flight frame has drained.
                    if ((cfg_point == c_point) || (pending_r == 2'd0)) begin
                        state_s      = ST_FILL;
                        load_point_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_FILL: begin
                if (wr_done_s) begin
                    state_s = (pending_s < 2'd2) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_HOLD: begin
                err_s = ~legal_s;
                if (pending_r < 2'd2) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Control state, occupancy and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 2'd0;
            wcnt_r    <= P_ZERO;
            c_point   <= MAX_POINT;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            err_point <= 1'b0;
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            s_ready   <= (state_s == ST_FILL);
            busy      <= (state_s == ST_FILL) | (pending_s != 2'd0);
            err_point <= err_s;
            c_point   <= load_point_s ? cfg_point : c_point;
            if (wr_done_s) begin
                wcnt_r <= P_ZERO;
            end else if (s_valid & s_ready) begin
                wcnt_r <= wcnt_r + PWIDTH'(1);
            end else begin
                wcnt_r <= wcnt_r;
            end
        end
    end

    // Input path register toward the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_data  <= {DWIDTH{1'b0}};
            c_valid <= 1'b0;
        end else begin
            c_data  <= s_data;
            c_valid <= s_valid & s_ready;
        end
    end

    // Output path register with frame boundary tagging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_data  <= {DWIDTH{1'b0}};
            m_valid <= 1'b0;
            m_sop   <= 1'b0;
            m_eop   <= 1'b0;
            rcnt_r  <= P_ZERO;
        end else begin
            m_data  <= c_o_data;
            m_valid <= c_o_valid;
            m_sop   <= rd_live_s & (rcnt_r == P_ZERO);
            m_eop   <= rd_eop_s;
            if (rd_eop_s) begin
                rcnt_r <= P_ZERO;
            end else if (rd_live_s) begin
                rcnt_r <= rcnt_r + PWIDTH'(1);
            end else begin
                rcnt_r <= rcnt_r;
            end
        end
    end

`ifdef BITREV_SCHED_STATS_EN
    // Frame counters wrap; stall counter saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_frames_in    <= 16'd0;
            o_frames_out   <= 16'd0;
            o_stall_cycles <= 16'd0;
        end else begin
            o_frames_in  <= wr_done_s ? (o_frames_in + 16'd1) : o_frames_in;
            o_frames_out <= rd_eop_s ? (o_frames_out + 16'd1) : o_frames_out;
            if (s_valid && !s_ready && (o_stall_cycles != 16'hFFFF)) begin
                o_stall_cycles <= o_stall_cycles + 16'd1;
            end else begin
                o_stall_cycles <= o_stall_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bitrev_frame_sched.sv
// Scoreboard bench for bitrev_frame_sched: expected core-side and output-side beats are
// queued as stimulus is driven and compared one cycle later on the falling edge.
module tb_bitrev_frame_sched;

    localparam int DW = 32;
    localparam int PW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] cfg_point;
    logic [DW-1:0] s_data, c_data, c_o_data, m_data;
    logic          s_valid, s_ready, c_valid, c_o_valid;
    logic [PW-1:0] c_point;
    logic          m_valid, m_sop, m_eop, err_point, busy;
`ifdef BITREV_SCHED_STATS_EN
    logic [15:0]   frames_in, frames_out, stall_cycles;
`endif

    bitrev_frame_sched #(.DWIDTH(DW), .PWIDTH(PW), .MIN_POINT(16)) dut (
        .clk(clk), .reset(reset), .cfg_point(cfg_point),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .c_data(c_data), .c_valid(c_valid), .c_point(c_point),
        .c_o_data(c_o_data), .c_o_valid(c_o_valid),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
        .err_point(err_point), .busy(busy)
`ifdef BITREV_SCHED_STATS_EN
        , .o_frames_in(frames_in), .o_frames_out(frames_out), .o_stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } m_exp_t;

    int            n_vec = 0;
    int            n_miss = 0;
    int            c_seen = 0;
    logic [DW-1:0] c_q[$];
    m_exp_t        m_q[$];
    m_exp_t        m_e;
    logic          exp_sop = 1'b0;
    logic          exp_eop = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop what was queued last falling edge, then queue this cycle's beats.
    always @(negedge clk) begin
        if (!reset) begin
            c_q.delete();
            m_q.delete();
        end else begin
            if (c_q.size() > 0) begin
                check_val("c_valid", c_valid, 1);
                check_val("c_data", c_data, c_q.pop_front());
                c_seen++;
            end else if (c_valid) begin
                check_val("c_valid_extra", c_valid, 0);
            end
            if (m_q.size() > 0) begin
                m_e = m_q.pop_front();
                check_val("m_valid", m_valid, 1);
                check_val("m_data", m_data, m_e.d);
                check_val("m_sop", m_sop, m_e.sop);
                check_val("m_eop", m_eop, m_e.eop);
            end else if (m_valid) begin
                check_val("m_valid_extra", m_valid, 0);
            end
            if (s_valid && s_ready) c_q.push_back(s_data);
            if (c_o_valid) m_q.push_back({c_o_data, exp_sop, exp_eop});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int n, input logic [DW-1:0] base, input bit park);
        int t;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + DW'(i);
            @(negedge clk);
            t = 0;
            while (!s_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!s_ready) begin
                check_val("send_timeout", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (park && i == 0) cfg_point = 11'd0;
        end
        s_valid = 1'b0;
    endtask

    task automatic emit(input int n, input int pt, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            c_o_valid = 1'b1;
            c_o_data  = base + DW'(i);
            exp_sop   = (i == 0);
            exp_eop   = (i == pt - 1);
            step(1);
        end
        c_o_valid = 1'b0;
        exp_sop   = 1'b0;
        exp_eop   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int t;
        cfg_point = 11'd64;
        s_valid   = 1'b0;
        s_data    = 32'd0;
        c_o_valid = 1'b0;
        c_o_data  = 32'd0;
        step(3);
        check_val("rst_s_ready", s_ready, 0);
        check_val("rst_c_point", c_point, 1024);
        check_val("rst_c_valid", c_valid, 0);
        check_val("rst_m_valid", m_valid, 0);
        check_val("rst_m_flags", {m_sop, m_eop}, 0);
        check_val("rst_err", err_point, 0);
        check_val("rst_busy", busy, 0);
        reset = 1'b1;

        // 64-point frame through both paths
        c0 = c_seen;
        send(64, 32'h1000, 1'b1);
        check_val("t1_busy_pending", busy, 1);
        check_val("t1_ready_after", s_ready, 0);
        step(1);
        check_val("t1_c_count", c_seen - c0, 64);
        step(4);
        emit(64, 64, 32'hA000);
        step(2);
        check_val("t1_busy_idle", busy, 0);
        check_val("t1_c_point", c_point, 64);
        check_val("t1_m_q_empty", m_q.size(), 0);

        // three 16-point frames, core held off
        cfg_point = 11'd16;
        send(32, 32'h2000, 1'b0);
        step(2);
        check_val("t2_hold_ready", s_ready, 0);
        check_val("t2_hold_busy", busy, 1);
        check_val("t2_c_point", c_point, 16);
        emit(16, 16, 32'hB000);
        step(2);
        check_val("t2_ready_after_eop", s_ready, 1);
        send(16, 32'h2100, 1'b1);
        emit(16, 16, 32'hB100);
        emit(16, 16, 32'hB200);
        step(3);
        check_val("t2_busy_done", busy, 0);

        // illegal then legal point size, then reset mid-frame
        cfg_point = 11'd48;
        step(5);
        check_val("t3_err_set", err_point, 1);
        check_val("t3_ready_blocked", s_ready, 0);
        check_val("t3_busy", busy, 0);
        cfg_point = 11'd32;
        step(1);
        check_val("t3_err_clear", err_point, 0);
        check_val("t3_fill", s_ready, 1);
        check_val("t3_c_point", c_point, 32);
        send(10, 32'h3000, 1'b0);
        reset = 1'b0;
        #1;
        check_val("t6_rst_ready", s_ready, 0);
        check_val("t6_rst_c_point", c_point, 1024);
        check_val("t6_rst_c_valid", c_valid, 0);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_err", err_point, 0);
        step(2);
        reset = 1'b1;
        c0 = c_seen;
        send(32, 32'h3100, 1'b1);
        check_val("t6_busy", busy, 1);
        step(2);
        check_val("t6_c_count", c_seen - c0, 32);
        emit(32, 32, 32'hC000);
        step(2);
        check_val("t6_busy_done", busy, 0);

        // reconfigure waits for drain
        cfg_point = 11'd128;
        send(128, 32'h4000, 1'b0);
        cfg_point = 11'd256;
        step(10);
        check_val("t4_ready_blocked", s_ready, 0);
        check_val("t4_c_point_old", c_point, 128);
        check_val("t4_busy", busy, 1);
        emit(128, 128, 32'hD000);
        step(1);
        check_val("t4_c_point_new", c_point, 256);
        check_val("t4_fill", s_ready, 1);
        send(256, 32'h4100, 1'b1);
        step(2);
        emit(256, 256, 32'hD100);
        step(2);
        check_val("t4_busy_done", busy, 0);

        // last write and eop in the same cycle
        cfg_point = 11'd16;
        send(16, 32'h5000, 1'b0);
        t = 0;
        while (!s_ready && t < 20) begin
            step(1);
            t++;
        end
        check_val("t5_fill_b", s_ready, 1);
        fork
            send(16, 32'h5100, 1'b0);
            emit(16, 16, 32'hE000);
        join
        step(1);
        check_val("t5_no_hold", s_ready, 1);
        check_val("t5_busy", busy, 1);
        send(16, 32'h5200, 1'b1);
        emit(16, 16, 32'hE100);
        emit(16, 16, 32'hE200);
        step(3);
        check_val("t5_busy_done", busy, 0);
        check_val("t5_c_q_empty", c_q.size(), 0);
        check_val("t5_m_q_empty", m_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
